// File: rtl/instr_fetch_seq.sv
// Instruction source: a small register-file program memory and an issue FSM that
// streams a requested number of words, in order, over a valid/ready handshake.
module instr_fetch_seq #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW:0]   num_instr,
    input  logic          start,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

    function automatic logic [AW:0] sat_count(input logic [AW:0] req);
        return (req > DEPTH_N) ? DEPTH_N : req;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   n_q, n_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] ptr_inc;
    logic          is_last;

    assign ptr_inc = ptr_q + 1'b1;
    assign is_last = ({1'b0, ptr_q} == (n_q - 1'b1));

    // Program memory is frozen while a run is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (state_q != S_ISSUE)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        n_d     = n_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_instr != '0) begin
                        n_d     = sat_count(num_instr);
                        ptr_d   = '0;
                        data_d  = mem_q[0];
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d  = ptr_inc;
                        data_d = mem_q[ptr_inc];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            n_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            n_q     <= n_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == S_ISSUE);
    assign busy      = (state_q == S_ISSUE);
    assign done      = (state_q == S_DONE);
    assign out_data  = data_q;
    assign out_idx   = ptr_q;
    assign out_last  = (state_q == S_ISSUE) && is_last;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: full runs, backpressure, zero-length,
// in-run write/start rejection, saturation and asynchronous reset mid-run.
module tb_instr_fetch_seq;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  num_instr;
    logic        start;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [8];

    instr_fetch_seq #(.DEPTH(8), .AW(3), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .num_instr (num_instr),
        .start     (start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input int idx, input logic last);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"},  out_data, prog[idx]);
        chk({tag, "_idx"},   {29'd0, out_idx}, idx);
        chk({tag, "_last"},  {31'd0, out_last}, {31'd0, last});
    endtask

    initial begin
        int j;
        int c;
        prog[0] = 32'h00221820; prog[1] = 32'h8C040004;
        prog[2] = 32'h08000010; prog[3] = 32'h00A62020;
        prog[4] = 32'h0C000020; prog[5] = 32'h2005000A;
        prog[6] = 32'h00E82820; prog[7] = 32'h00000000;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        num_instr = '0; start = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_idx",   {29'd0, out_idx}, 32'd0);
        chk("rst_last",  {31'd0, out_last}, 32'd0);
        step();
        rst = 1'b0;

        // Load program
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = prog[i];
            step();
        end
        wr_en = 1'b0;

        // Full run, ready held high
        start = 1'b1; num_instr = 4'd8; out_ready = 1'b1;
        step();
        start = 1'b0;
        chk("run8_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk_word("run8", i, i == 7);
            step();
        end
        chk("run8_done",   {31'd0, done}, 32'd1);
        chk("run8_vldoff", {31'd0, out_valid}, 32'd0);
        step();
        chk("run8_done_end", {31'd0, done}, 32'd0);

        // Backpressure with ready pattern 1,0,0,1
        start = 1'b1; num_instr = 4'd8;
        step();
        start = 1'b0;
        j = 0;
        c = 0;
        while (j < 8 && c < 64) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            chk_word("bp", j, j == 7);
            if (out_ready) j++;
            c++;
            step();
        end
        chk("bp_count", j, 32'd8);
        chk("bp_done", {31'd0, done}, 32'd1);
        out_ready = 1'b1;
        step();

        // Zero-length run
        start = 1'b1; num_instr = 4'd0;
        step();
        start = 1'b0;
        chk("zero_done",  {31'd0, done}, 32'd1);
        chk("zero_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("zero_done_end", {31'd0, done}, 32'd0);
        chk("zero_valid2",   {31'd0, out_valid}, 32'd0);

        // Three-word run with write and start attempted mid-run
        start = 1'b1; num_instr = 4'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_word("run3", i, i == 2);
            if (i == 1) begin
                wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'hDEADBEEF;
                start = 1'b1; num_instr = 4'd8;
            end
            step();
            wr_en = 1'b0; start = 1'b0;
        end
        chk("run3_done", {31'd0, done}, 32'd1);
        step();
        chk("run3_idle_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("run3_no_restart", {31'd0, out_valid}, 32'd0);
        chk("run3_no_done",    {31'd0, done}, 32'd0);
        start = 1'b1; num_instr = 4'd2;
        step();
        start = 1'b0;
        chk_word("mem1", 0, 1'b0);
        step();
        chk_word("mem1", 1, 1'b1);
        step();
        chk("mem1_done", {31'd0, done}, 32'd1);
        step();

        // Saturating request
        start = 1'b1; num_instr = 4'd12;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_word("sat", i, i == 7);
            step();
        end
        chk("sat_done",  {31'd0, done}, 32'd1);
        chk("sat_valid", {31'd0, out_valid}, 32'd0);
        step();

        // Asynchronous reset after two handshakes
        start = 1'b1; num_instr = 4'd8;
        step();
        start = 1'b0;
        step();
        step();
        chk_word("prerst", 2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_busy",  {31'd0, busy}, 32'd0);
        chk("arst_data",  out_data, 32'd0);
        chk("arst_done",  {31'd0, done}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("arst_nodone", {31'd0, done}, 32'd0);
        end
        start = 1'b1; num_instr = 4'd1;
        step();
        start = 1'b0;
        chk("arst_mem_valid", {31'd0, out_valid}, 32'd1);
        chk("arst_mem_data",  out_data, 32'd0);
        chk("arst_mem_last",  {31'd0, out_last}, 32'd1);
        step();
        chk("arst_mem_done", {31'd0, done}, 32'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
